// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings for the byte-serial memory controller.
//   state_e   : FSM state encodings
//   SZ_*      : lsu_size codes (3 is decoded as a word)
//   IO_BASE_DFLT : first I/O address; reads at or above it are never replayed
//   txn_t     : context latched when a transaction is accepted
//   byte_cnt  : lsu_size -> number of bytes on the bus
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE     = 2'd0;
  localparam logic [1:0] SZ_HALF     = 2'd1;
  localparam logic [1:0] SZ_WORD     = 2'd2;
  localparam logic [1:0] SZ_WORD_ALT = 2'd3;

  localparam logic [31:0] IO_BASE_DFLT = 32'h0003_0000;

  typedef struct packed {
    logic [31:0] base;   // byte 0 address
    logic [31:0] wdata;  // store data, byte k goes out in write cycle k
    logic [2:0]  n;      // byte count, 1..4
    logic        is_if;  // owner: 1 = fetch, 0 = LSU
    logic        io;     // touches I/O space: no speculation, no replay
  } txn_t;

  function automatic logic [2:0] byte_cnt(input logic [1:0] size);
    case (size)
      SZ_BYTE:              byte_cnt = 3'd1;
      SZ_HALF:              byte_cnt = 3'd2;
      SZ_WORD, SZ_WORD_ALT: byte_cnt = 3'd4;
      default:              byte_cnt = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: shares the single 8-bit, 1-cycle-latency memory port between
// instruction fetch and the LSU. Word/halfword accesses are split into
// byte cycles; read data is assembled little-endian and zero-extended.
// The whole block freezes while rdy_in is low (debug owns the bus).
//
// Ports
//   clk_in, rst_in (sync, active high), rdy_in (0 = freeze)
//   flush                 : abort an in-flight fetch
//   if_req/if_addr        : 4-byte fetch request (level)
//   if_done/if_data       : one-cycle completion pulse + word
//   lsu_req/lsu_wr/lsu_size/lsu_addr/lsu_wdata : load/store request (level)
//   lsu_done/lsu_rdata    : one-cycle completion pulse + load data
//   mem_din               : read byte, valid one cycle after its address
//   mem_a/mem_dout/mem_wr : registered byte address, write data, write strobe
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DFLT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsu_req,
  input  logic        lsu_wr,
  input  logic [1:0]  lsu_size,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  // vld_pipe[0]: mem_a holds an issued read address this cycle
  // vld_pipe[1]: mem_din carries the byte for cap_q this cycle
  localparam int STAGES = 1;

  state_e            state_q, state_d;
  txn_t              txn_q, txn_d;
  logic [2:0]        iss_q, iss_d, cap_q, cap_d, cap_nx;
  logic [STAGES:0]   vld_pipe, vld_d;
  logic [31:0]       data_q, data_d, data_cap;
  logic [31:0]       mem_a_q, mem_a_d, rw_a;
  logic [7:0]        dout_q, dout_d;
  logic              wr_q, wr_d;
  logic              if_done_q, if_done_d, lsu_done_q, lsu_done_d;
  logic [31:0]       if_data_q, if_data_d, lsu_rdata_q, lsu_rdata_d;
  logic              rdy_q, resume;

  function automatic logic is_io(input logic [31:0] a);
    return a >= IO_BASE;
  endfunction

  function automatic txn_t mk_txn(input logic [31:0] a, input logic [31:0] wd,
                                  input logic [2:0] n, input logic is_if);
    txn_t t;
    t.base  = a;
    t.wdata = wd;
    t.n     = n;
    t.is_if = is_if;
    t.io    = is_io(a) | is_io(a + {29'd0, n} - 32'd1);
    return t;
  endfunction

  // First ready cycle after a stall in a RAM read: whatever was in flight
  // was lost to the debug master, so re-present the oldest uncaptured byte
  // right now instead of waiting a cycle for a registered rewind.
  assign cap_nx = cap_q + 3'd1;
  assign rw_a   = txn_q.base + {29'd0, cap_q};
  assign resume = rdy_in & ~rdy_q & (state_q == ST_READ) & ~txn_q.io;

  assign mem_a     = resume ? rw_a : mem_a_q;
  assign mem_dout  = dout_q;
  assign mem_wr    = wr_q;
  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign lsu_done  = lsu_done_q;
  assign lsu_rdata = lsu_rdata_q;

  always_comb begin
    data_cap = data_q;
    data_cap[{cap_q[1:0], 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    state_d     = state_q;
    txn_d       = txn_q;
    iss_d       = iss_q;
    cap_d       = cap_q;
    vld_d       = vld_pipe;
    data_d      = data_q;
    mem_a_d     = mem_a_q;
    dout_d      = dout_q;
    wr_d        = 1'b0;
    if_done_d   = 1'b0;
    lsu_done_d  = 1'b0;
    if_data_d   = if_data_q;
    lsu_rdata_d = lsu_rdata_q;

    case (state_q)
      ST_IDLE: begin
        // Byte 0 is issued straight from the accept cycle.
        if (lsu_req) begin
          txn_d   = mk_txn(lsu_addr, lsu_wdata, byte_cnt(lsu_size), 1'b0);
          mem_a_d = lsu_addr;
          iss_d   = 3'd1;
          cap_d   = 3'd0;
          data_d  = '0;
          if (lsu_wr) begin
            dout_d  = lsu_wdata[7:0];
            wr_d    = 1'b1;
            vld_d   = '0;
            state_d = ST_WRITE;
          end else begin
            vld_d   = 2'b01;
            state_d = ST_READ;
          end
        end else if (if_req && !flush) begin
          txn_d   = mk_txn(if_addr, 32'd0, 3'd4, 1'b1);
          mem_a_d = if_addr;
          iss_d   = 3'd1;
          cap_d   = 3'd0;
          data_d  = '0;
          vld_d   = 2'b01;
          state_d = ST_READ;
        end
      end

      ST_READ: begin
        if (txn_q.is_if && flush) begin
          vld_d   = '0;
          state_d = ST_IDLE;
        end else if (resume) begin
          // mem_a shows base+cap this cycle; nothing valid on mem_din yet.
          vld_d = 2'b10;
          if (cap_nx < txn_q.n) begin
            mem_a_d  = rw_a + 32'd1;
            iss_d    = cap_nx + 3'd1;
            vld_d[0] = 1'b1;
          end else begin
            mem_a_d = rw_a;
            iss_d   = cap_nx;
          end
        end else begin
          vld_d[1] = vld_pipe[0];
          vld_d[0] = 1'b0;
          if (vld_pipe[1]) begin
            cap_d  = cap_nx;
            data_d = data_cap;
          end
          // I/O: one byte in flight at most, and mem_a is left on the
          // current address until its byte has been taken.
          if (iss_q < txn_q.n && (!txn_q.io || !vld_pipe[0])) begin
            mem_a_d  = txn_q.base + {29'd0, iss_q};
            iss_d    = iss_q + 3'd1;
            vld_d[0] = 1'b1;
          end
          if (vld_pipe[1] && cap_nx == txn_q.n) begin
            vld_d   = '0;
            state_d = ST_DONE;
            if (txn_q.is_if) begin
              if_done_d = 1'b1;
              if_data_d = data_cap;
            end else begin
              lsu_done_d  = 1'b1;
              lsu_rdata_d = data_cap;
            end
          end
        end
      end

      ST_WRITE: begin
        // Outputs simply hold across a stall, so the held byte lands in RAM
        // on the first ready cycle without any extra bookkeeping.
        if (iss_q < txn_q.n) begin
          mem_a_d = txn_q.base + {29'd0, iss_q};
          dout_d  = txn_q.wdata[{iss_q[1:0], 3'b000} +: 8];
          wr_d    = 1'b1;
          iss_d   = iss_q + 3'd1;
        end else begin
          lsu_done_d = 1'b1;
          state_d    = ST_DONE;
        end
      end

      ST_DONE: begin
        vld_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      txn_q       <= '0;
      iss_q       <= '0;
      cap_q       <= '0;
      vld_pipe    <= '0;
      data_q      <= '0;
      mem_a_q     <= '0;
      dout_q      <= '0;
      wr_q        <= 1'b0;
      if_done_q   <= 1'b0;
      lsu_done_q  <= 1'b0;
      if_data_q   <= '0;
      lsu_rdata_q <= '0;
      rdy_q       <= 1'b1;
    end else begin
      rdy_q <= rdy_in;
      if (rdy_in) begin
        state_q     <= state_d;
        txn_q       <= txn_d;
        iss_q       <= iss_d;
        cap_q       <= cap_d;
        vld_pipe    <= vld_d;
        data_q      <= data_d;
        mem_a_q     <= mem_a_d;
        dout_q      <= dout_d;
        wr_q        <= wr_d;
        if_done_q   <= if_done_d;
        lsu_done_q  <= lsu_done_d;
        if_data_q   <= if_data_d;
        lsu_rdata_q <= lsu_rdata_d;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scenarios for mem_ctrl with a response scoreboard
// (done pulses) and a write scoreboard (bus write cycles). The stimulus
// pushes expectations; one negedge monitor pops and compares them.
module tb_mem_ctrl;
  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush, if_req, lsu_req, lsu_wr;
  logic [31:0] if_addr, lsu_addr, lsu_wdata;
  logic [1:0]  lsu_size;
  logic        if_done, lsu_done, mem_wr;
  logic [31:0] if_data, lsu_rdata, mem_a;
  logic [7:0]  mem_din, mem_dout;

  mem_ctrl #(.IO_BASE(IO_BASE)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsu_req(lsu_req), .lsu_wr(lsu_wr), .lsu_size(lsu_size),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_done(lsu_done),
    .lsu_rdata(lsu_rdata), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // RAM below IO_BASE; I/O space returns addr[7:0]^5A. While the bus is
  // borrowed the CPU side sees garbage and its writes are not applied.
  logic [7:0] ram [0:4095];
  always @(posedge clk_in) begin
    if (rdy_in) begin
      if (mem_wr && !rst_in && mem_a < IO_BASE) ram[mem_a[11:0]] <= mem_dout;
      mem_din <= (mem_a >= IO_BASE) ? (mem_a[7:0] ^ 8'h5A) : ram[mem_a[11:0]];
    end else begin
      mem_din <= 8'hEE;
    end
  end

  typedef struct {
    logic        is_if;
    logic [31:0] data;
    logic        chk;
    int          cyc;
  } resp_t;
  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
    int          cyc;
  } wr_t;

  resp_t resp_q[$];
  wr_t   wr_q[$];
  int    checks = 0, passes = 0, resp_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail_now(input string nm);
    checks++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  always @(negedge clk_in) begin
    resp_t r;
    wr_t   w;
    if (if_done || lsu_done) begin
      resp_cnt++;
      if (if_done && lsu_done) fail_now("done_both");
      else if (resp_q.size() == 0) fail_now("done_unexpected");
      else begin
        r = resp_q.pop_front();
        check("done_kind", {31'd0, if_done}, {31'd0, r.is_if});
        check("done_cycle", cyc, r.cyc);
        if (r.chk) check("done_data", r.is_if ? if_data : lsu_rdata, r.data);
      end
    end
    if (mem_wr && rdy_in) begin
      if (wr_q.size() == 0) fail_now("write_unexpected");
      else begin
        w = wr_q.pop_front();
        check("wr_addr", mem_a, w.a);
        check("wr_data", {24'd0, mem_dout}, {24'd0, w.d});
        check("wr_cycle", cyc, w.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic go_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push_resp(input logic is_if, input logic [31:0] d, input logic chk, input int c);
    resp_t r;
    r.is_if = is_if; r.data = d; r.chk = chk; r.cyc = c;
    resp_q.push_back(r);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d, input int c);
    wr_t w;
    w.a = a; w.d = d; w.cyc = c;
    wr_q.push_back(w);
  endtask

  // Returns in the cycle after the done pulse (requester drops req here).
  task automatic wait_resp(input int n0, input string nm);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (resp_cnt > n0) return;
    end
    fail_now({nm, "_timeout"});
  endtask

  task automatic set_ram(input int a, input logic [31:0] w);
    logic [31:0] v;
    v = w;
    for (int k = 0; k < 4; k++) ram[a + k] = v[8*k +: 8];
  endtask

  int t0, n0;

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    set_ram(32'h10,  32'h9305_0013);
    set_ram(32'h20,  32'h0403_0201);
    ram[32'h100] = 8'h5C;
    set_ram(32'h1FE, 32'h4433_2211);
    set_ram(32'h40,  32'hD4C3_B2A1);
    set_ram(32'h50,  32'hDEAD_BEEF);
    set_ram(32'h60,  32'h4030_2010);
    set_ram(32'h70,  32'h6745_2301);

    rst_in = 1; rdy_in = 1; flush = 0; if_req = 0; lsu_req = 0; lsu_wr = 0;
    if_addr = 0; lsu_addr = 0; lsu_wdata = 0; lsu_size = 0;
    repeat (3) tick();
    @(negedge clk_in);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_dones", {30'd0, if_done, lsu_done}, 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_lsu_rdata", lsu_rdata, 32'd0);
    tick();
    rst_in = 0;
    repeat (2) tick();

    // Fetch: word at 0x10, done in cycle 6.
    t0 = cyc; n0 = resp_cnt;
    if_addr = 32'h10; if_req = 1;
    push_resp(1, 32'h9305_0013, 1, t0 + 6);
    wait_resp(n0, "fetch");
    if_req = 0;
    repeat (2) tick();

    // Contention: LSU byte read wins (done 3), IF accepted in cycle 4.
    t0 = cyc; n0 = resp_cnt;
    if_addr = 32'h20; if_req = 1;
    lsu_addr = 32'h100; lsu_size = 2'd0; lsu_wr = 0; lsu_req = 1;
    push_resp(0, 32'h0000_005C, 1, t0 + 3);
    push_resp(1, 32'h0403_0201, 1, t0 + 10);
    wait_resp(n0, "cont_lsu");
    lsu_req = 0;
    n0 = resp_cnt;
    go_to(t0 + 5);
    @(negedge clk_in);
    check("cont_if_addr_c5", mem_a, 32'h20);
    wait_resp(n0, "cont_if");
    if_req = 0;
    repeat (2) tick();

    // Store halfword across 0x1FF/0x200.
    t0 = cyc; n0 = resp_cnt;
    lsu_addr = 32'h1FF; lsu_size = 2'd1; lsu_wr = 1; lsu_wdata = 32'hAABB_CCDD; lsu_req = 1;
    push_wr(32'h1FF, 8'hDD, t0 + 1);
    push_wr(32'h200, 8'hCC, t0 + 2);
    push_resp(0, 32'd0, 0, t0 + 3);
    wait_resp(n0, "store");
    lsu_req = 0; lsu_wr = 0;
    tick();
    check("store_1fe", {24'd0, ram[32'h1FE]}, 32'h11);
    check("store_1ff", {24'd0, ram[32'h1FF]}, 32'hDD);
    check("store_200", {24'd0, ram[32'h200]}, 32'hCC);
    check("store_201", {24'd0, ram[32'h201]}, 32'h44);
    tick();

    // Read stall in cycles 2..4: replay from byte 0 in cycle 5, done 10.
    t0 = cyc; n0 = resp_cnt;
    if_addr = 32'h40; if_req = 1;
    push_resp(1, 32'hD4C3_B2A1, 1, t0 + 10);
    go_to(t0 + 2);
    rdy_in = 0;
    @(negedge clk_in);
    check("stall_hold_addr", mem_a, 32'h41);
    go_to(t0 + 5);
    rdy_in = 1;
    @(negedge clk_in);
    check("stall_rewind_c5", mem_a, 32'h40);
    wait_resp(n0, "stall");
    if_req = 0;
    repeat (2) tick();

    // Flush in cycle 3 of a fetch; pending LSU word read accepted in cycle 4.
    t0 = cyc; n0 = resp_cnt;
    if_addr = 32'h50; if_req = 1;
    go_to(t0 + 1);
    lsu_addr = 32'h60; lsu_size = 2'd2; lsu_wr = 0; lsu_req = 1;
    push_resp(0, 32'h4030_2010, 1, t0 + 10);
    go_to(t0 + 3);
    flush = 1; if_req = 0;
    go_to(t0 + 4);
    flush = 0;
    go_to(t0 + 5);
    @(negedge clk_in);
    check("flush_lsu_addr_c5", mem_a, 32'h60);
    wait_resp(n0, "flush");
    lsu_req = 0;
    repeat (2) tick();

    // I/O halfword read: no speculative address, done in cycle 5.
    t0 = cyc; n0 = resp_cnt;
    lsu_addr = IO_BASE; lsu_size = 2'd1; lsu_wr = 0; lsu_req = 1;
    push_resp(0, 32'h0000_5B5A, 1, t0 + 5);
    go_to(t0 + 2);
    @(negedge clk_in);
    check("io_no_spec_c2", mem_a, IO_BASE);
    wait_resp(n0, "io");
    lsu_req = 0;
    repeat (2) tick();

    // lsu_size 3 decodes as a word.
    t0 = cyc; n0 = resp_cnt;
    lsu_addr = 32'h70; lsu_size = 2'd3; lsu_req = 1;
    push_resp(0, 32'h6745_2301, 1, t0 + 6);
    wait_resp(n0, "size3");
    lsu_req = 0;
    repeat (2) tick();

    // Reset in cycle 2 of a word store.
    t0 = cyc;
    lsu_addr = 32'h80; lsu_size = 2'd2; lsu_wr = 1; lsu_wdata = 32'h1122_3344; lsu_req = 1;
    push_wr(32'h80, 8'h44, t0 + 1);
    push_wr(32'h81, 8'h33, t0 + 2);
    go_to(t0 + 2);
    rst_in = 1; lsu_req = 0; lsu_wr = 0;
    go_to(t0 + 3);
    @(negedge clk_in);
    check("rst_mid_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mid_mem_a", mem_a, 32'd0);
    check("rst_mid_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_mid_dones", {30'd0, if_done, lsu_done}, 32'd0);
    check("rst_mid_lsu_rdata", lsu_rdata, 32'd0);
    check("rst_mid_if_data", if_data, 32'd0);
    tick();
    rst_in = 0;
    repeat (3) tick();
    check("rst_ram_80", {24'd0, ram[32'h80]}, 32'h44);
    check("rst_ram_81", {24'd0, ram[32'h81]}, 32'h00);
    check("rst_ram_83", {24'd0, ram[32'h83]}, 32'h00);

    check("resp_q_empty", resp_q.size(), 32'd0);
    check("wr_q_empty", wr_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
